multicycle_data_memory: RTL and testbench

Parametrised successor to the single-cycle data memory. It serves one load or store at a time over a valid/ready request port, with a configurable fixed latency. It supports byte, halfword and word accesses with sign or zero extension, and flags misaligned or out-of-range accesses. It sits between the MEM stage (or a future cache's refill path) and the backing word array, which it zero-clears itself after reset.

---
 rtl/multicycle_data_memory_if.sv | 24 ++
 rtl/multicycle_data_memory.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_data_memory.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_data_memory_if.sv
// Request/response bus of the multicycle data memory.
// master drives requests and observes responses; slave is the memory side.
interface multicycle_data_memory_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/multicycle_data_memory.sv
// Multicycle data memory: one load/store at a time, fixed latency, byte/half/word
// accesses with sign/zero extension and error flagging. The word array is swept
// to zero after every reset before the first request is accepted.
// Optional macro DMEM_TRACE_EN prints one line per response.
module multicycle_data_memory #(
    parameter int unsigned MEM_DEPTH = 16384,
    parameter int unsigned LATENCY   = 4
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_data_memory_if.slave  bus
);
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {StClear, StIdle, StBusy, StResp} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [31:0]     addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [MEM_DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_idx;
    logic [31:0]     mem_wdata;

    // With LATENCY==1 the access completes on the acceptance edge, so the
    // operation fields come straight from the bus while idle.
    logic            accept, finish;
    logic            op_write, op_unsigned, op_err, in_range;
    logic [31:0]     op_addr, op_wdata;
    logic [1:0]      op_size;
    logic [AW-1:0]   word_idx;
    logic [31:0]     rd_word, shifted, lane_mask, merged, load_val;
    logic [4:0]      shamt;

    assign accept      = (state_q == StIdle) && bus.req_valid;
    assign finish      = ((state_q == StBusy) && (cnt_q == 8'd1)) || (accept && (LATENCY == 1));
    assign op_write    = (state_q == StIdle) ? bus.req_write    : write_q;
    assign op_addr     = (state_q == StIdle) ? bus.req_addr     : addr_q;
    assign op_size     = (state_q == StIdle) ? bus.req_size     : size_q;
    assign op_unsigned = (state_q == StIdle) ? bus.req_unsigned : unsigned_q;
    assign op_wdata    = (state_q == StIdle) ? bus.req_wdata    : wdata_q;

    assign word_idx = op_addr[AW+1:2];
    assign in_range = op_addr[31:2] < 30'(MEM_DEPTH);
    assign op_err   = (op_size == 2'b11) || ((op_size == 2'b01) && op_addr[0]) ||
                      ((op_size == 2'b10) && (op_addr[1:0] != 2'b00)) || !in_range;
    assign rd_word  = in_range ? mem[word_idx] : 32'h0;
    assign shamt    = {op_addr[1:0], 3'b000};
    assign shifted  = rd_word >> shamt;
    assign merged   = (rd_word & ~lane_mask) | ((op_wdata << shamt) & lane_mask);

    // Lane mask for stores and extended load value.
    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        load_val  = shifted;
        unique case (op_size)
            2'b00: begin
                lane_mask = 32'h0000_00FF << shamt;
                load_val  = {{24{!op_unsigned && shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                lane_mask = 32'h0000_FFFF << shamt;
                load_val  = {{16{!op_unsigned && shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    // Next-state, latching and array write control.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        rdata_d    = 32'h0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = clr_idx_q;
        mem_wdata  = 32'h0;
        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(MEM_DEPTH - 1)) begin
                    clr_idx_d = '0;
                    state_d   = StIdle;
                end
            end
            StIdle: begin
                if (bus.req_valid) begin
                    write_d    = bus.req_write;
                    addr_d     = bus.req_addr;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    wdata_d    = bus.req_wdata;
                    if (LATENCY > 1) begin
                        state_d = StBusy;
                        cnt_d   = 8'(LATENCY - 1);
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = StResp;
            end
            StResp: state_d = StIdle;
            default: state_d = StClear;
        endcase
        if (finish) begin
            err_d = op_err;
            if (!op_err) begin
                if (op_write) begin
                    mem_we    = 1'b1;
                    mem_idx   = word_idx;
                    mem_wdata = merged;
                end else begin
                    rdata_d = load_val;
                end
            end
        end
    end

    // Control state; reset abandons any pending store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StClear;
            clr_idx_q  <= '0;
            cnt_q      <= 8'd0;
            write_q    <= 1'b0;
            addr_q     <= 32'h0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Word array; not reset, the clear sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

`ifdef DMEM_TRACE_EN
    // One trace line per response; for stores the array already holds the merged word.
    always_ff @(posedge clk) begin
        if (state_q == StResp) begin
            $display("DMEM %s addr=0x%08x data=0x%08x err=%0d", write_q ? "W" : "R", addr_q,
                     write_q ? (err_q ? 32'h0 : mem[addr_q[AW+1:2]]) : rdata_q, err_q);
        end
    end
`endif

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_multicycle_data_memory.sv
// Scoreboard bench: stimulus pushes expected responses, per-DUT monitors pop and
// compare data, error flag and acceptance-to-response edge count.
module tb_multicycle_data_memory;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_data_memory_if if4 ();
    multicycle_data_memory_if if1 ();

    multicycle_data_memory #(.MEM_DEPTH(DEPTH), .LATENCY(4)) dut (
        .clk(clk), .reset(reset), .bus(if4.slave)
    );
    multicycle_data_memory #(.MEM_DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic u, input logic [31:0] d);
        if (sel) begin
            if1.req_valid = v; if1.req_write = w; if1.req_addr = a;
            if1.req_size = s; if1.req_unsigned = u; if1.req_wdata = d;
        end else begin
            if4.req_valid = v; if4.req_write = w; if4.req_addr = a;
            if4.req_size = s; if4.req_unsigned = u; if4.req_wdata = d;
        end
    endtask

    // Waits for ready, presents one request, records the acceptance edge number.
    task automatic issue(input bit sel, input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] d, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit noise, output int acc);
        int n = 0;
        exp_t e;
        acc = -1;
        @(negedge clk);
        while (!(sel ? if1.req_ready : if4.req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        drive(sel, 1'b1, w, a, s, u, d);
        acc = cyc + 1;
        e.rdata = exp_rdata;
        e.err = exp_err;
        e.acc = acc;
        if (sel) q1.push_back(e); else q4.push_back(e);
        @(negedge clk);
        if (noise) begin
            for (int k = 0; k < 3; k++) begin
                drive(sel, 1'b1, 1'b1, 32'h8, 2'b10, 1'b0, 32'h0000_0100 * k);
                @(negedge clk);
            end
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    endtask

    // Asserts reset while checking outputs collapse, then times the clear sweep.
    task automatic do_reset();
        int n = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        q4.delete();
        q1.delete();
        check("rst_req_ready", {31'b0, if4.req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, if4.resp_valid}, 32'd0);
        check("rst_resp_rdata", if4.resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, if4.resp_err}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        while (!if4.req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("clear_cycles", n, DEPTH);
    endtask

    // Monitor for the LATENCY=4 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if4.resp_valid === 1'b1) begin
                if (q4.size() == 0) begin
                    check("dut4_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    check("dut4_rdata", if4.resp_rdata, e.rdata);
                    check("dut4_err", {31'b0, if4.resp_err}, {31'b0, e.err});
                    check("dut4_latency", cyc - e.acc + 1, 32'd4);
                end
            end
        end
    end

    // Monitor for the LATENCY=1 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if1.resp_valid === 1'b1) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("dut1_rdata", if1.resp_rdata, e.rdata);
                    check("dut1_err", {31'b0, if1.resp_err}, {31'b0, e.err});
                    check("dut1_latency", cyc - e.acc + 1, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        do_reset();

        // Cleared array, word store/load and back-to-back spacing.
        issue(0, 0, 32'h0, 2'b10, 0, 32'h0, 32'h0, 0, 0, a0);
        issue(0, 1, 32'h8, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0, 0, a0);
        issue(0, 0, 32'h8, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 0, a1);
        check("dut4_accept_spacing", a1 - a0, 32'd5);

        // Sub-word stores and loads.
        issue(0, 1, 32'h9, 2'b00, 0, 32'h12345680, 32'h0, 0, 0, a0);
        issue(0, 0, 32'h8, 2'b10, 0, 32'h0, 32'hDEAD80EF, 0, 0, a0);
        issue(0, 0, 32'h9, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0, 0, a0);
        issue(0, 0, 32'h9, 2'b00, 1, 32'h0, 32'h00000080, 0, 0, a0);
        issue(0, 0, 32'hA, 2'b01, 0, 32'h0, 32'hFFFFDEAD, 0, 0, a0);
        issue(0, 0, 32'hA, 2'b01, 1, 32'h0, 32'h0000DEAD, 0, 0, a0);
        issue(0, 1, 32'h4, 2'b10, 0, 32'h11223344, 32'h0, 0, 0, a0);
        issue(0, 1, 32'h6, 2'b01, 0, 32'hAAAA5566, 32'h0, 0, 0, a0);
        issue(0, 0, 32'h7, 2'b00, 1, 32'h0, 32'h00000055, 0, 0, a0);

        // Error cases.
        issue(0, 1, 32'h6, 2'b10, 0, 32'hFFFFFFFF, 32'h0, 1, 0, a0);
        issue(0, 0, 32'h4, 2'b10, 0, 32'h0, 32'h55663344, 0, 0, a0);
        issue(0, 0, 32'h40, 2'b10, 0, 32'h0, 32'h0, 1, 0, a0);
        issue(0, 0, 32'h0, 2'b11, 0, 32'h0, 32'h0, 1, 0, a0);
        issue(0, 0, 32'h5, 2'b01, 0, 32'h0, 32'h0, 1, 0, a0);

        // Request inputs toggling during BUSY are ignored.
        issue(0, 0, 32'h8, 2'b10, 0, 32'h0, 32'hDEAD80EF, 0, 1, a0);
        issue(0, 0, 32'h8, 2'b10, 0, 32'h0, 32'hDEAD80EF, 0, 0, a0);

        // LATENCY=1 instance: back-to-back requests.
        issue(1, 1, 32'h10, 2'b10, 0, 32'h0BADF00D, 32'h0, 0, 0, a0);
        issue(1, 0, 32'h10, 2'b10, 0, 32'h0, 32'h0BADF00D, 0, 0, a1);
        check("dut1_accept_spacing", a1 - a0, 32'd2);
        issue(1, 0, 32'h13, 2'b00, 1, 32'h0, 32'h0000000B, 0, 0, a0);
        repeat (6) @(negedge clk);

        // Reset during a pending store drops it.
        issue(0, 1, 32'h4, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0, 0, a0);
        check("busy_before_reset", {31'b0, if4.req_ready}, 32'd0);
        do_reset();
        issue(0, 0, 32'h4, 2'b10, 0, 32'h0, 32'h0, 0, 0, a0);

        repeat (10) @(negedge clk);
        check("dut4_queue_drained", q4.size(), 32'd0);
        check("dut1_queue_drained", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
